mainband_pattern_generator: RTL
===============================

// Module: mainband_pattern_generator
// PURPOSE
//  TX-side pattern source for the D2C point test. Consumes the 2-bit generator control word and valid-pattern enable
//  from the TX-initiated point-test controller. Drives per-lane LFSR or per-lane-ID data onto the mainband lanes and
//  VALTRAIN onto the valid lane. Returns a finished flag, which the controller takes as i_pattern_finished.
// PARAMETERS
//  NUM_LANES   16    mainband data lanes
//  W           8     UI per lane per clk (parallel slice width, bit0 = first UI)
//  PATTERN_UI  4096  UI per burst; must be a multiple of 2*W
// PORTS
//  clk                              in   1           core clock
//  rst                              in   1           synchronous reset, active-high
//  i_en                             in   1           block enable; low forces IDLE
//  i_mainband_pattern_generator_cw  in   2           00 idle/clear, 01 LFSR, 10 per-lane ID, 11 reserved (= 00)
//  i_val_pattern_en                 in   1           drive VALTRAIN on the valid lane
//  o_mb_data                        out  NUM_LANES*W lane k in bits [k*W +: W]
//  o_mb_data_valid                  out  1           o_mb_data carries pattern this cycle
//  o_valid_lane                     out  W           valid-lane slice
//  o_pattern_finished               out  1           burst complete; level signal
// BEHAVIOUR
//  Clock and reset
//   - Single clock domain; reset is sampled only on the clk rising edge.
//   - All outputs are registered. Reset value of every output is 0; FSM resets to IDLE; counter resets to 0.
//  FSM states: IDLE, LOAD, RUN, DONE. Let go = i_en && cw in {01,10}.
//   IDLE: o_mb_data=0, valid=0, finished=0. go -> LOAD and latch mode (01/10).
//   LOAD: one cycle. Seed every lane LFSR from SEED[k]; clear UI counter; outputs still 0 -> RUN.
//   RUN: each cycle present the next W UI per lane with o_mb_data_valid=1. Counter runs 0..PATTERN_UI/W-1.
//        On the last count -> DONE.
//   DONE: data=0, valid=0, o_pattern_finished=1 (held). Leave to IDLE when cw==00/11 or !i_en. A new go is not
//         honoured until IDLE has been visited.
//  Latency: cw 00->01 sampled at edge N; LOAD at N+1; first valid data at edge N+2. finished rises the edge after
//   the last data slice. Burst length is exactly PATTERN_UI/W valid cycles (512 at defaults).
//  Abort: cw leaving the latched mode, or i_en low, in LOAD/RUN -> IDLE next edge. Data and valid go 0 that edge;
//   finished is not set. A mode change 01<->10 mid-RUN counts as an abort; the new mode is not adopted.
//  Simultaneous cases: rst wins over everything. The counter wrap and an abort on the same edge resolve to IDLE,
//   not DONE.
//  LFSR: one per lane, 23-bit Galois, polynomial x^23+x^21+x^16+x^8+x^5+x^2+1. Output UI = lfsr[22], then the
//   register steps; this is unrolled W times per clk. SEED[k] = SEED_TBL[k%8].
//  Per-lane ID: 16-UI word {4'hA, lane_id[7:0], 4'hA} sent LSB first. Even RUN cycles send word[W-1:0], odd cycles
//   send word[15:W] (W=8). The word repeats for the whole burst.
//  Valid lane: i_val_pattern_en=1 (any state) gives o_valid_lane = 8'b0000_1111 (4 UI high then 4 low, repeating)
//   from the next edge; 0 gives 0. This is independent of the FSM so the valtrain test needs no cw.
//  Width rules: counter width = clog2(PATTERN_UI/W)+1; no overflow is possible since the counter resets in LOAD.
// STRUCTURE
//  - Package ucie_pattern_pkg holds:
//    - CW_IDLE/CW_LFSR/CW_PERLANE/CW_RSVD constants and the FSM state typedef.
//    - LFSR_POLY; SEED_TBL[8] = 1DBFBC,0607BB,1EC760,18C0DB,010F12,19CFC9,0277CE,1BB807 (hex).
//    - VALTRAIN_WORD = 8'h0F and PERLANE_NIBBLE = 4'hA.
//  - Sub-module ucie_lfsr_lane (params W, SEED): inputs clk, rst, load, step; output W-bit slice. It is instantiated
//    NUM_LANES times with generate. The FSM, counter, per-lane-ID mux and valid lane stay in the top.
// TESTING
//  1 Reset: hold rst 3 cycles with cw=01 -> all outputs 0, FSM IDLE; release -> LOAD, then valid at +2 edges.
//  2 LFSR burst: cw=01 -> exactly 512 valid cycles. Lane0 first slice equals a reference model seeded 1DBFBC;
//    lane8 equals lane0. finished rises the edge after the last slice; after cw=00, finished=0 next edge.
//  3 Per-lane ID: cw=10 -> lane5 slices alternate 8'h5A, 8'hA0 and lane15 slices alternate 8'hFA, 8'hA0 for all
//    512 cycles.
//  4 Abort: cw=01, drop i_en at RUN cycle 100 -> valid=0 next edge, finished never set. Re-enable -> the burst
//    restarts from the seed.
//  5 Valtrain: cw=00, i_val_pattern_en=1 -> o_valid_lane=8'h0F every cycle from the next edge, o_mb_data=0.
//  6 Hold in DONE: keep cw=01 after finish -> no second burst and finished stays 1 until cw=00.

Source files
------------

// File: rtl/ucie_pattern_pkg.sv
// Shared constants and types for the D2C point-test mainband pattern source.
package ucie_pattern_pkg;

    localparam int unsigned LFSR_W = 23;

    // Generator control word encodings
    localparam logic [1:0] CW_IDLE    = 2'b00;
    localparam logic [1:0] CW_LFSR    = 2'b01;
    localparam logic [1:0] CW_PERLANE = 2'b10;
    localparam logic [1:0] CW_RSVD    = 2'b11;

    // Generator FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // x^23+x^21+x^16+x^8+x^5+x^2+1, tap mask applied after the left shift
    localparam logic [LFSR_W-1:0] LFSR_POLY = 23'h210125;

    localparam logic [LFSR_W-1:0] SEED_TBL [8] = '{
        23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
        23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
    };

    localparam logic [7:0] VALTRAIN_WORD  = 8'h0F;
    localparam logic [3:0] PERLANE_NIBBLE = 4'hA;

endpackage

// File: rtl/ucie_lfsr_lane.sv
// One mainband lane LFSR: 23-bit Galois register unrolled W UI per clock.
module ucie_lfsr_lane
    import ucie_pattern_pkg::*;
#(
    parameter int unsigned       W    = 8,
    parameter logic [LFSR_W-1:0] SEED = 23'h1DBFBC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] slice_c
);

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic              fb;

    // Emit W UI from the current state (MSB first out) and compute the state W steps ahead
    always_comb begin
        lfsr_next = lfsr;
        slice_c   = '0;
        fb        = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            fb         = lfsr_next[LFSR_W-1];
            slice_c[i] = fb;
            lfsr_next  = {lfsr_next[LFSR_W-2:0], 1'b0} ^ ({LFSR_W{fb}} & LFSR_POLY);
        end
    end

    // State register: reseed on load, advance one slice per step
    always_ff @(posedge clk) begin
        if (rst || load) begin
            lfsr <= SEED;
        end else if (step) begin
            lfsr <= lfsr_next;
        end
    end

endmodule

// File: rtl/mainband_pattern_generator.sv
// TX pattern source for the D2C point test: per-lane LFSR or lane-ID bursts plus VALTRAIN.
module mainband_pattern_generator
    import ucie_pattern_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 16,
    parameter int unsigned W          = 8,
    parameter int unsigned PATTERN_UI = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic [1:0]             i_mainband_pattern_generator_cw,
    input  logic                   i_val_pattern_en,
    output logic [NUM_LANES*W-1:0] o_mb_data,
    output logic                   o_mb_data_valid,
    output logic [W-1:0]           o_valid_lane,
    output logic                   o_pattern_finished
);

    localparam int unsigned BURST = PATTERN_UI / W;
    localparam int unsigned CNT_W = $clog2(BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    state_t                 state, state_next;
    logic [1:0]             mode, mode_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [NUM_LANES*W-1:0] data_next;
    logic                   valid_next;
    logic                   finished_next;
    logic [NUM_LANES*W-1:0] pattern_c;
    logic [15:0]            id_word;
    logic                   go;
    logic                   abort;
    logic                   leave_done;
    logic                   lfsr_load;
    logic                   lfsr_step;
    logic [W-1:0]           lane_slice [NUM_LANES];

    assign lfsr_load = (state == ST_LOAD);
    assign lfsr_step = (state == ST_RUN);

    // Lane LFSR bank; seeds repeat every eight lanes
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        ucie_lfsr_lane #(
            .W    (W),
            .SEED (SEED_TBL[3'(k % 8)])
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (lfsr_load),
            .step    (lfsr_step),
            .slice_c (lane_slice[k])
        );
    end

    // Per-cycle lane payload: LFSR slice or alternating halves of the lane-ID word
    always_comb begin
        pattern_c = '0;
        id_word   = '0;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            id_word = {PERLANE_NIBBLE, 8'(k), PERLANE_NIBBLE};
            if (mode == CW_LFSR) begin
                pattern_c[k*W +: W] = lane_slice[k];
            end else if (cnt[0]) begin
                pattern_c[k*W +: W] = id_word[W +: W];
            end else begin
                pattern_c[k*W +: W] = id_word[0 +: W];
            end
        end
    end

    // Next-state, counter and next-output decode
    always_comb begin
        state_next    = state;
        mode_next     = mode;
        cnt_next      = cnt;
        data_next     = '0;
        valid_next    = 1'b0;
        finished_next = 1'b0;

        go         = i_en && ((i_mainband_pattern_generator_cw == CW_LFSR) ||
                              (i_mainband_pattern_generator_cw == CW_PERLANE));
        abort      = !i_en || (i_mainband_pattern_generator_cw != mode);
        leave_done = !i_en || (i_mainband_pattern_generator_cw == CW_IDLE) ||
                     (i_mainband_pattern_generator_cw == CW_RSVD);

        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_next = ST_LOAD;
                    mode_next  = i_mainband_pattern_generator_cw;
                end
            end
            ST_LOAD: begin
                cnt_next   = '0;
                state_next = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                // Abort outranks the wrap so a late abort never reports finished
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    data_next  = pattern_c;
                    valid_next = 1'b1;
                    cnt_next   = cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (leave_done) begin
                    state_next = ST_IDLE;
                end else begin
                    finished_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            mode               <= CW_IDLE;
            cnt                <= '0;
            o_mb_data          <= '0;
            o_mb_data_valid    <= 1'b0;
            o_pattern_finished <= 1'b0;
            o_valid_lane       <= '0;
        end else begin
            state              <= state_next;
            mode               <= mode_next;
            cnt                <= cnt_next;
            o_mb_data          <= data_next;
            o_mb_data_valid    <= valid_next;
            o_pattern_finished <= finished_next;
            o_valid_lane       <= i_val_pattern_en ? W'(VALTRAIN_WORD) : '0;
        end
    end

endmodule
